// File: rtl/csr_arb_pkg.sv
// rtl/csr_arb_pkg.sv - shared types and default sizes for the CSR bus arbiter
package csr_arb_pkg;

  localparam int CSR_NUM_REQ  = 4;
  localparam int CSR_AW       = 8;
  localparam int CSR_DW       = 32;
  localparam int CSR_NUM_REGS = 2;
  localparam int IDX_W        = $clog2(CSR_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [CSR_AW-1:0] addr;
    logic [CSR_DW-1:0] wdata;
    logic              oor;
    logic [IDX_W-1:0]  idx;
  } cmd_t;

  function automatic logic [CSR_NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [CSR_NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/csr_rr_arbiter.sv
// rtl/csr_rr_arbiter.sv - round-robin winner select with a registered priority pointer
module csr_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               gnt_en_i,
  output logic               valid_o,
  output logic [IW-1:0]      win_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // Scan from the farthest offset down so the request nearest ptr_q is the last to assign.
  always_comb begin
    int j;
    logic [IW-1:0] cand;
    valid_o   = 1'b0;
    win_idx_o = '0;
    j         = 0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IW'(j);
      if (req_i[cand]) begin
        valid_o   = 1'b1;
        win_idx_o = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_en_i && valid_o) begin
      ptr_d = (win_idx_o == IW'(NUM_REQ - 1)) ? '0 : win_idx_o + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/csr_bus_arbiter.sv
// rtl/csr_bus_arbiter.sv - shares one CSR map port between requesters, one strobe per transaction
module csr_bus_arbiter
  import csr_arb_pkg::*;
#(
  parameter int NUM_REQ  = CSR_NUM_REQ,
  parameter int AW       = CSR_AW,
  parameter int DW       = CSR_DW,
  parameter int NUM_REGS = CSR_NUM_REGS
) (
  input  logic                  reg_clk_i,
  input  logic                  reg_rst_n_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    req_wr_i,
  input  logic [NUM_REQ*AW-1:0] req_addr_i,
  input  logic [NUM_REQ*DW-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic                  rsp_err_o,
  output logic [DW-1:0]         rsp_rdata_o,
  output logic                  reg_wr_en_o,
  output logic                  reg_rd_en_o,
  output logic [AW-1:0]         reg_addr_o,
  output logic [DW-1:0]         reg_wr_data_o,
  input  logic [DW-1:0]         reg_rd_data_i
);

  state_t           state_q;
  cmd_t             cmd_q;
  cmd_t             cmd_d;
  logic [DW-1:0]    rdata_q;
  logic             arb_valid;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_take;

  assign arb_take = (state_q == IDLE) && arb_valid;

  csr_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk_i    (reg_clk_i),
    .rst_n_i  (reg_rst_n_i),
    .req_i    (req_i),
    .gnt_en_i (arb_take),
    .valid_o  (arb_valid),
    .win_idx_o(arb_idx)
  );

  always_comb begin
    cmd_d       = '0;
    cmd_d.wr    = req_wr_i[arb_idx];
    cmd_d.addr  = req_addr_i[int'(arb_idx)*AW +: AW];
    cmd_d.wdata = req_wdata_i[int'(arb_idx)*DW +: DW];
    cmd_d.oor   = (req_addr_i[int'(arb_idx)*AW +: AW] >= AW'(NUM_REGS));
    cmd_d.idx   = arb_idx;
  end

  // rdata_q is cleared on accept so writes and errors respond with zero data.
  always_ff @(posedge reg_clk_i or negedge reg_rst_n_i) begin
    if (!reg_rst_n_i) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_valid) begin
            cmd_q   <= cmd_d;
            rdata_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE:   state_q <= (!cmd_q.oor && !cmd_q.wr) ? WAIT : DONE;
        WAIT: begin
          rdata_q <= reg_rd_data_i;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt_o         = '0;
    rsp_valid_o   = '0;
    rsp_err_o     = 1'b0;
    rsp_rdata_o   = '0;
    reg_wr_en_o   = 1'b0;
    reg_rd_en_o   = 1'b0;
    reg_addr_o    = '0;
    reg_wr_data_o = '0;
    if (state_q == ISSUE) begin
      gnt_o = idx_to_onehot(cmd_q.idx);
      if (!cmd_q.oor) begin
        reg_wr_en_o   = cmd_q.wr;
        reg_rd_en_o   = !cmd_q.wr;
        reg_addr_o    = cmd_q.addr;
        reg_wr_data_o = cmd_q.wdata;
      end
    end
    if (state_q == DONE) begin
      rsp_valid_o = idx_to_onehot(cmd_q.idx);
      rsp_err_o   = cmd_q.oor;
      rsp_rdata_o = rdata_q;
    end
  end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb/tb_csr_bus_arbiter.sv - table, directed and randomized checks of csr_bus_arbiter against a transaction model
module tb_csr_bus_arbiter;

  localparam int NR    = 4;
  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int NREGS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NR-1:0]     req, req_wr;
  logic [AW-1:0]     a [NR];
  logic [DW-1:0]     d [NR];
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     gnt, rsp_valid;
  logic              rsp_err, wr_en, rd_en;
  logic [DW-1:0]     rsp_rdata, reg_wdata, map_rdata;
  logic [AW-1:0]     reg_addr;

  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign req_addr[k*AW +: AW]  = a[k];
    assign req_wdata[k*DW +: DW] = d[k];
  end

  csr_bus_arbiter dut (
    .reg_clk_i    (clk),
    .reg_rst_n_i  (rst_n),
    .req_i        (req),
    .req_wr_i     (req_wr),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .gnt_o        (gnt),
    .rsp_valid_o  (rsp_valid),
    .rsp_err_o    (rsp_err),
    .rsp_rdata_o  (rsp_rdata),
    .reg_wr_en_o  (wr_en),
    .reg_rd_en_o  (rd_en),
    .reg_addr_o   (reg_addr),
    .reg_wr_data_o(reg_wdata),
    .reg_rd_data_i(map_rdata)
  );

  // Register map stand-in: storage with a one-cycle registered read, noise when not read.
  logic [DW-1:0] map_mem [NREGS];
  always @(posedge clk) begin
    if (wr_en && reg_addr < AW'(NREGS)) map_mem[reg_addr[0]] <= reg_wdata;
    if (rd_en && reg_addr < AW'(NREGS)) map_rdata <= map_mem[reg_addr[0]];
    else map_rdata <= $urandom;
  end

  int vectors = 0;
  int fails   = 0;

  typedef struct {
    logic [NR-1:0] gnt;
    logic [NR-1:0] rsp;
    logic          err;
    logic [DW-1:0] rdata;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          chk_bus;
  } exp_t;

  exp_t          q[$];
  exp_t          cur;
  int            ptr;
  logic [DW-1:0] mmem [NREGS];

  function automatic exp_t blank_rec();
    exp_t e;
    e.gnt = '0; e.rsp = '0; e.err = 1'b0; e.rdata = '0;
    e.we = 1'b0; e.re = 1'b0; e.addr = '0; e.wd = '0; e.chk_bus = 1'b1;
    return e;
  endfunction

  // Each accepted transaction becomes a timeline of per-cycle expectations.
  task automatic model_step();
    exp_t eg, er;
    int   g;
    logic oor, rd;
    if (q.size() == 0 && req != '0) begin
      g = -1;
      for (int i = 0; i < NR; i++) if (g < 0 && req[(ptr + i) % NR]) g = (ptr + i) % NR;
      ptr = (g + 1) % NR;
      oor = (a[g] >= AW'(NREGS));
      rd  = !oor && !req_wr[g];
      eg = blank_rec();
      er = blank_rec();
      eg.gnt = NR'(1) << g;
      eg.chk_bus = !oor;
      if (!oor) begin
        eg.we = req_wr[g]; eg.re = !req_wr[g]; eg.addr = a[g]; eg.wd = d[g];
      end
      er.rsp = NR'(1) << g;
      er.err = oor;
      if (rd) er.rdata = mmem[a[g][0]];
      if (!oor && req_wr[g]) mmem[a[g][0]] = d[g];
      q.push_back(eg);
      if (rd) q.push_back(blank_rec());
      q.push_back(er);
      q.push_back(blank_rec());
    end
    if (q.size() != 0) cur = q.pop_front();
    else cur = blank_rec();
  endtask

  task automatic model_reset();
    q.delete();
    ptr = 0;
    cur = blank_rec();
  endtask

  task automatic check_model();
    logic bad;
    bad = (gnt !== cur.gnt) || (rsp_valid !== cur.rsp) || (rsp_err !== cur.err) ||
          (rsp_rdata !== cur.rdata) || (wr_en !== cur.we) || (rd_en !== cur.re) ||
          (cur.chk_bus && ((reg_addr !== cur.addr) || (reg_wdata !== cur.wd)));
    vectors++;
    if (bad) begin
      fails++;
      $display("FAIL model t=%0t act/exp gnt %b/%b rsp %b/%b err %b/%b rdata %h/%h we %b/%b re %b/%b addr %h/%h wd %h/%h",
               $time, gnt, cur.gnt, rsp_valid, cur.rsp, rsp_err, cur.err, rsp_rdata, cur.rdata,
               wr_en, cur.we, rd_en, cur.re, reg_addr, cur.addr, reg_wdata, cur.wd);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"},   64'({gnt, rsp_valid, rsp_err, wr_en, rd_en}), 64'(0));
    chk({nm, "_rdata"}, 64'(rsp_rdata), 64'(0));
    chk({nm, "_addr"},  64'(reg_addr), 64'(0));
    chk({nm, "_wdata"}, 64'(reg_wdata), 64'(0));
  endtask

  task automatic new_cmd(input int k);
    req_wr[k] = 1'($urandom_range(0, 1));
    a[k]      = AW'($urandom_range(0, 3));
    d[k]      = $urandom;
  endtask

  typedef struct {
    int            k;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
  } tv_t;
  tv_t tbl[6];

  initial begin
    int   k, n, f, s;
    int   order[$];
    int   cyc[$];
    int   exp_order[6];
    logic prev_strobe;

    tbl[0] = '{0, 1'b1, 8'h00, 32'h0000_80AB, 1'b0, 32'h0000_0000, 1};
    tbl[1] = '{3, 1'b1, 8'h01, 32'hC000_0015, 1'b0, 32'h0000_0000, 1};
    tbl[2] = '{2, 1'b0, 8'h01, 32'h1234_5678, 1'b0, 32'hC000_0015, 2};
    tbl[3] = '{1, 1'b0, 8'h05, 32'h0000_0000, 1'b1, 32'h0000_0000, 1};
    tbl[4] = '{0, 1'b1, 8'hFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1};
    tbl[5] = '{3, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 32'h0000_80AB, 2};
    exp_order = '{0, 1, 2, 3, 0, 1};

    rst_n = 1'b0;
    req = '0;
    req_wr = '0;
    for (int i = 0; i < NR; i++) begin a[i] = '0; d[i] = '0; end
    model_reset();
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) begin
      k = tbl[t].k;
      req[k] = 1'b1; req_wr[k] = tbl[t].wr; a[k] = tbl[t].addr; d[k] = tbl[t].wdata;
      tick();
      chk("tbl_gnt", 64'(gnt), 64'(NR'(1) << k));
      chk("tbl_strobe", 64'({wr_en, rd_en}), tbl[t].err ? 64'(0) : (tbl[t].wr ? 64'(2) : 64'(1)));
      if (!tbl[t].err) chk("tbl_addr", 64'(reg_addr), 64'(tbl[t].addr));
      if (!tbl[t].err && tbl[t].wr) chk("tbl_wdata", 64'(reg_wdata), 64'(tbl[t].wdata));
      req[k] = 1'b0;
      repeat (tbl[t].lat) tick();
      chk("tbl_rsp", 64'(rsp_valid), 64'(NR'(1) << k));
      chk("tbl_err", 64'(rsp_err), 64'(tbl[t].err));
      chk("tbl_rdata", 64'(rsp_rdata), 64'(tbl[t].rdata));
      tick();
    end

    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < NR; i++) begin req[i] = 1'b1; req_wr[i] = 1'b0; a[i] = AW'(i % 2); end
    @(negedge clk);
    rst_n = 1'b1;
    prev_strobe = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("adjacent_strobes", 64'(prev_strobe && (wr_en || rd_en)), 64'(0));
      prev_strobe = wr_en || rd_en;
      for (int i = 0; i < NR; i++) if (gnt[i]) begin order.push_back(i); cyc.push_back(c); end
    end
    chk("rr_grant_count_ge6", 64'(order.size() >= 6), 64'(1));
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      chk("rr_order", 64'(order[i]), 64'(exp_order[i]));
      if (i > 0) chk("rr_spacing", 64'(cyc[i] - cyc[i-1]), 64'(4));
    end
    req = '0;
    repeat (6) tick();

    req[3] = 1'b1; req_wr[3] = 1'b0; a[3] = 8'h01;
    n = 0;
    do begin tick(); n++; end while (!gnt[3] && n < 10);
    chk("rst_case_gnt3", 64'(gnt[3]), 64'(1));
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_gnt3", 64'(gnt), 64'(4'b1000));
    req[3] = 1'b0;
    repeat (5) tick();

    req[2] = 1'b1; req_wr[2] = 1'b1; a[2] = 8'h00; d[2] = 32'hA5A5_0002;
    n = 0;
    do begin tick(); n++; end while (!gnt[2] && n < 10);
    chk("ptr_case_gnt2", 64'(gnt[2]), 64'(1));
    req[2] = 1'b0;
    req[1] = 1'b1; req_wr[1] = 1'b0; a[1] = 8'h00;
    req[3] = 1'b1; req_wr[3] = 1'b1; a[3] = 8'h01; d[3] = 32'h5A5A_0003;
    order.delete();
    n = 0;
    while (order.size() < 2 && n < 20) begin
      tick();
      n++;
      for (int i = 0; i < NR; i++) if (gnt[i]) begin order.push_back(i); req[i] = 1'b0; end
    end
    f = (order.size() > 0) ? order[0] : 99;
    s = (order.size() > 1) ? order[1] : 99;
    chk("ptr_case_first", 64'(f), 64'(3));
    chk("ptr_case_second", 64'(s), 64'(1));
    repeat (6) tick();

    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (cur.gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else new_cmd(i);
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          new_cmd(i);
        end
      end
    end
    req = '0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
